// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status and memory arbiter FSM states.
package cpu_types_pkg;

    // Status reported by the RAM model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Which cache currently owns the RAM port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and dcache reads/writes onto a single RAM port.
// Data wins ties; a streak counter forces a pending fetch through after
// DSTREAK_MAX back-to-back data completions.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DSTREAK_MAX = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [CNT_W-1:0] StreakMax = CNT_W'(DSTREAK_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] streak_q, streak_d;

    logic d_req;
    logic ram_access;
    logic data_done;
    logic instr_done;

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == ACCESS);

    // State and streak registers; reset drops every RAM enable at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Next-state and all outputs, decoded from the owner of the RAM port.
    always_comb begin
        state_d    = state_q;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        data_done  = 1'b0;
        instr_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A pending fetch that has waited out a full streak beats data.
                if (d_req && !(iREN && (streak_q == StreakMax))) begin
                    state_d = DATA;
                end else if (iREN) begin
                    state_d = INSTR;
                end
            end

            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;  // write wins when both are raised
                dload    = ramload;
                dwait    = ~ram_access;
                if (!d_req) begin
                    state_d = IDLE;       // withdrawn: no completion counted
                end else if (ram_access) begin
                    state_d   = IDLE;
                    data_done = 1'b1;
                end
            end

            INSTR: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = ramload;
                iwait   = ~ram_access;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    state_d    = IDLE;
                    instr_done = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Streak only grows while a fetch is actually waiting behind data.
    always_comb begin
        streak_d = streak_q;
        if (!iREN || instr_done) begin
            streak_d = '0;
        end else if (data_done && (streak_q != StreakMax)) begin
            streak_d = streak_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against an ownership model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int DMAX = 4;
    localparam int OwnNone  = 0;
    localparam int OwnData  = 1;
    localparam int OwnInstr = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DSTREAK_MAX(DMAX), .CNT_W(3)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    int checks = 0;
    int errors = 0;
    int owner  = OwnNone;   // who holds the RAM port in the model
    int streak = 0;         // data completions seen while a fetch waits

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from who owns the port and the present inputs.
    task automatic check_all(input string ctx);
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        logic        acc;
        acc = (ramstate == ACCESS);
        e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
        if (owner == OwnData) begin
            e_addr = daddr; e_store = dstore; e_dload = ramload;
            e_wen = dWEN; e_ren = dREN && !dWEN; e_dwait = !acc;
        end else if (owner == OwnInstr) begin
            e_addr = iaddr; e_iload = ramload; e_ren = iREN; e_iwait = !acc;
        end
        chk({ctx, ".iwait"}, iwait, e_iwait);
        chk({ctx, ".dwait"}, dwait, e_dwait);
        chk({ctx, ".ramREN"}, ramREN, e_ren);
        chk({ctx, ".ramWEN"}, ramWEN, e_wen);
        chk({ctx, ".ramaddr"}, ramaddr, e_addr);
        chk({ctx, ".ramstore"}, ramstore, e_store);
        chk({ctx, ".iload"}, iload, e_iload);
        chk({ctx, ".dload"}, dload, e_dload);
    endtask

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_edge();
        bit acc, dreq, ddone, idone;
        int nxt;
        acc   = (ramstate == ACCESS);
        dreq  = dREN || dWEN;
        ddone = (owner == OwnData) && dreq && acc;
        idone = (owner == OwnInstr) && iREN && acc;
        nxt   = owner;
        case (owner)
            OwnNone:  if (dreq && !(iREN && streak == DMAX)) nxt = OwnData;
                      else if (iREN) nxt = OwnInstr;
            OwnData:  if (!dreq || acc) nxt = OwnNone;
            default:  if (!iREN || acc) nxt = OwnNone;
        endcase
        if (!iREN || idone) streak = 0;
        else if (ddone && streak < DMAX) streak++;
        owner = nxt;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    task automatic settle(input string ctx);
        #1;
        check_all(ctx);
    endtask

    task automatic edge_step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        settle("idle");
        edge_step();
    endtask

    int  dcnt;
    bit  fetched;

    initial begin
        // Reset held with a fetch pending: nothing may reach the RAM.
        nRST = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        nRST = 1'b1;

        // Single fetch: arbitration cycle, two BUSY, then ACCESS.
        settle("fetch_arb");
        chk("fetch_arb_ren", ramREN, 1'b0);
        edge_step();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        settle("fetch_busy0");
        chk("rst_release_ren", ramREN, 1'b1);
        chk("rst_release_addr", ramaddr, 32'h40);
        edge_step();
        settle("fetch_busy1");
        edge_step();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h2108_0004);
        settle("fetch_access");
        chk("fetch_iwait", iwait, 1'b0);
        chk("fetch_iload", iload, 32'h2108_0004);
        edge_step();
        drive(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        settle("fetch_after");
        chk("fetch_back_idle", ramREN, 1'b0);
        edge_step();

        // Simultaneous requests: data first, then one idle cycle, then fetch.
        drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h800, 32'h0, FREE, 32'h0);
        settle("simul_arb");
        edge_step();
        drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h800, 32'h0, ACCESS, 32'h1234_5678);
        settle("simul_data");
        chk("simul_addr", ramaddr, 32'h800);
        chk("simul_dload", dload, 32'h1234_5678);
        edge_step();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h800, 32'h0, FREE, 32'h0);
        settle("simul_gap");
        chk("simul_gap_ren", ramREN, 1'b0);
        edge_step();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h800, 32'h0, ACCESS, 32'hCAFE_0001);
        settle("simul_fetch");
        chk("simul_fetch_addr", ramaddr, 32'h44);
        edge_step();
        go_idle();

        // Starvation bound: count data completions before the first fetch completes.
        dcnt = 0;
        fetched = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h900 + 32'(i), 32'h0, ACCESS, 32'(i) + 32'h100);
            settle("starve");
            if (!fetched && dwait === 1'b0) dcnt++;
            if (iwait === 1'b0) fetched = 1'b1;
            edge_step();
        end
        chk("starve_dcount", 32'(dcnt), 32'd4);
        chk("starve_fetched", {31'b0, fetched}, 32'd1);
        go_idle();

        // Write with both enables raised: write wins.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hF00, 32'hDEAD_BEEF, FREE, 32'h0);
        settle("wr_arb");
        edge_step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hF00, 32'hDEAD_BEEF, BUSY, 32'h0);
        settle("wr_busy");
        chk("wr_wen", ramWEN, 1'b1);
        chk("wr_ren", ramREN, 1'b0);
        chk("wr_store", ramstore, 32'hDEAD_BEEF);
        edge_step();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hF00, 32'hDEAD_BEEF, ACCESS, 32'h0);
        settle("wr_access");
        chk("wr_dwait", dwait, 1'b0);
        edge_step();
        go_idle();

        // Withdrawal during BUSY.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, FREE, 32'h0);
        settle("wd_arb");
        edge_step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, BUSY, 32'h0);
        settle("wd_busy");
        edge_step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'hA00, 32'h0, BUSY, 32'h0);
        settle("wd_drop");
        chk("wd_ren_drop", ramREN, 1'b0);
        edge_step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, BUSY, 32'h0);
        settle("wd_rearb");
        chk("wd_idle_ren", ramREN, 1'b0);
        edge_step();
        go_idle();

        // Reset asserted mid-fetch.
        drive(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        settle("mr_arb");
        edge_step();
        settle("mr_busy");
        #2;
        nRST = 1'b0;
        #1;
        owner  = OwnNone;
        streak = 0;
        chk("mr_ren", ramREN, 1'b0);
        chk("mr_iwait", iwait, 1'b1);
        check_all("mr_reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        go_idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom);
            settle("rand");
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly downstream of icache and dcache, between their cif ports and the single-ported RAM.
- Arbitrates instruction fetches and data read/write requests onto one RAM port.
- Returns wait/load handshakes to each cache.
- Data requests take priority. A bounded streak counter guarantees instruction fetches cannot starve.

Parameters:
- DSTREAK_MAX, 4: consecutive completed data transactions allowed while a fetch is pending before the fetch is forced through.
- CNT_W, 3: streak counter width; must satisfy 2^CNT_W > DSTREAK_MAX.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  high = fetch not complete
- iload  out  32  fetched instruction
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  high = data access not complete
- dload  out  32  read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset (async, nRST low):
  - state = IDLE; streak = 0.
  - iwait = 1, dwait = 1.
  - ramREN/ramWEN/ramaddr/ramstore = 0.
  - iload/dload = 0.
- FSM states are IDLE, DATA and INSTR. The state is registered; all outputs are combinational from state and inputs.
- IDLE:
  - No RAM enables; both waits = 1.
  - Next state = DATA if (dREN|dWEN) and not (iREN and streak == DSTREAK_MAX).
  - Otherwise next state = INSTR if iREN; otherwise IDLE.
  - Every grant therefore costs one arbitration cycle.
- DATA:
  - ramaddr = daddr; ramstore = dstore; ramWEN = dWEN; ramREN = dREN & ~dWEN (write wins if both are asserted); dload = ramload.
  - dwait = ~(ramstate == ACCESS). iwait = 1.
- INSTR:
  - ramaddr = iaddr; ramREN = iREN; iload = ramload.
  - iwait = ~(ramstate == ACCESS). dwait = 1.
- Completion: the ramstate == ACCESS cycle in DATA or INSTR → next state is IDLE, never a direct re-grant. The requester's enable is still high in that cycle and must not be re-arbitrated.
- Withdrawal: if the granted requester drops all its enables while in DATA/INSTR, RAM enables drop that same cycle and the next state is IDLE. No completion is counted.
- BUSY and ERROR are treated as not done. The arbiter keeps driving the request and holds the wait high. No timeout.
- No preemption: a grant is held until completion or withdrawal, regardless of other requests.
- Streak counter:
  - Increments (saturating at DSTREAK_MAX) on each DATA completion while iREN = 1.
  - Clears on INSTR completion.
  - Clears on any cycle with iREN = 0.
- Non-granted outputs: iload = 0 when not in INSTR; dload = 0 when not in DATA.
- Reset mid-transaction aborts immediately to the reset values. No RAM enable may remain asserted after nRST falls.

Decomposition:
- arb_state_t (IDLE, DATA, INSTR) and the existing ramstate_t belong in cpu_types_pkg.
- DSTREAK_MAX stays a module parameter.
- No sub-module is needed. The single FSM plus counter is compact enough to keep flat.

Test Plan:
- Reset: hold nRST = 0 with iREN = 1 → iwait = 1, dwait = 1, ramREN = 0, ramWEN = 0. Release → ramREN = 1, ramaddr = iaddr one cycle later.
- Single fetch: iREN = 1, iaddr = 0x0000_0040; RAM gives BUSY 2 cycles then ACCESS with ramload = 0x2108_0004 → iwait low only in the ACCESS cycle, iload = 0x2108_0004, then state returns to IDLE.
- Simultaneous request: iREN = 1 and dREN = 1 (daddr = 0x0000_0800) in IDLE → DATA granted first; ramaddr = 0x800; fetch is granted only after the data ACCESS plus one IDLE cycle.
- Starvation bound: dREN and iREN held high, RAM returns ACCESS on every request → exactly 4 data completions, then INSTR granted; streak clears to 0 after the fetch.
- Write: dWEN = 1 and dREN = 1, daddr = 0x0000_0F00, dstore = 0xDEAD_BEEF → ramWEN = 1, ramREN = 0, ramstore = 0xDEAD_BEEF; dwait falls on ACCESS.
- Withdrawal and mid-op reset: drop dREN during BUSY → ramREN = 0 in the same cycle, next state IDLE, streak unchanged. Assert nRST during INSTR/BUSY → ramREN = 0 and iwait = 1 immediately.
